seq_stage_sequencer: RTL
========================

# seq_stage_sequencer

Multi-cycle control FSM for the SEQ Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, asserting one stage enable per cycle. It owns the architectural PC register and selects the next PC from valP/valC/valM. It also tracks processor status (AOK/HLT/ADR/INS) and performs the data-memory request/ready handshake.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  leave IDLE and begin fetching at PC
- icode  input  4  instruction code from fetch stage (valid from FETCH cycle onward)
- instr_valid  input  1  fetch decoded a legal icode/ifun
- imem_error  input  1  fetch address out of range
- Cnd  input  1  condition result from execute (valid from EXECUTE cycle onward)
- valP  input  64  fall-through address
- valC  input  64  constant word / jump or call target
- valM  input  64  value read from data memory (return address for ret)
- mem_ready  input  1  data memory completed current access
- dmem_error  input  1  data memory address error, qualified by mem_ready
- PC  output  64  architectural program counter
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  output  1 each  stage enables, one-hot or all-zero
- mem_req  output  1  data memory access request
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- halted  output  1  FSM in HALT
- instr_count  output  64  count of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Each stage state drives only its own enable. All enables are 0 in IDLE and HALT.
- Reset values: state IDLE, PC=RESET_PC, stat=1 (AOK), instr_count=0, mem_req=0, halted=0, all enables 0.
- IDLE -> FETCH when start=1. Otherwise hold. start is ignored in all other states.
- End of FETCH, checked in priority order:
  - imem_error -> stat=3, go to HALT.
  - Else !instr_valid -> stat=4, go to HALT.
  - Else icode==0 (halt) -> stat=2, go to HALT.
  - Else go to DECODE.
- DECODE -> EXECUTE -> MEMORY, unconditionally.
- Memory icodes are 4 (rmmovq), 5 (mrmovq), 8 (call), 9 (ret), A (pushq) and B (popq).
  - For a memory icode, MEMORY holds with mem_req=1 until mem_ready=1.
  - When mem_ready=1 and dmem_error=1: stat=3, go to HALT. No WRITEBACK, no PC update, no count.
  - When mem_ready=1 and dmem_error=0: go to WRITEBACK.
  - Non-memory icodes spend exactly 1 cycle in MEMORY with mem_req=0; mem_ready is ignored.
- WRITEBACK -> PCUPD unconditionally.
- PCUPD: PC is loaded with next PC, instr_count increments by 1 (wraps modulo 2^64), then go to FETCH.
- Next PC selection:
  - icode 7 with Cnd=1 -> valC.
  - icode 8 -> valC.
  - icode 9 -> valM.
  - All other cases, including icode 7 with Cnd=0 -> valP.
- HALT: terminal. halted=1, PC and instr_count frozen, stat holds its fault code. Exit is by rst only.
- A HALT caused by icode 0 leaves PC pointing at the halt instruction and does not count it.

## Timing
- State and all outputs are registered. Enables reflect the current state.
- Non-memory instruction: 6 cycles from FETCH to the next FETCH.
- Memory instruction: 6 + N cycles, where N is the number of cycles mem_req is high before mem_ready (N=0 if mem_ready is high on the first MEMORY cycle).
- mem_req rises on entry to MEMORY and falls on the edge at which mem_ready=1 is sampled.
- PC and instr_count change on the rising edge that ends the PCUPD cycle. The new PC is visible in the following FETCH cycle.
- stat and halted update on the edge that enters HALT.
- rst=1 at any edge forces all reset values regardless of state, including mid-MEMORY with mem_req high.

## Test plan
- Reset, start=1 for 1 cycle, icode=3 (irmovq), valP=0x0A -> enables step F,D,E,M,W,P over 6 cycles; PC=0x0A and instr_count=1 after the PCUPD edge; mem_req never asserted.
- icode=7, valC=0x100, valP=0x09: Cnd=1 -> PC=0x100; repeated with Cnd=0 -> PC=0x09.
- icode=8 (call), valC=0x200, mem_ready delayed 3 cycles -> MEMORY held 4 cycles with mem_req=1, then PC=0x200. Next, icode=9 with valM=0x13 -> PC=0x13.
- Halt sources, each from reset:
  - icode=0 -> stat=2, halted=1, PC unchanged, all enables 0.
  - imem_error=1 -> stat=3.
  - instr_valid=0 -> stat=4.
  - In each case, start pulses have no effect until rst.
- icode=5 with mem_ready=1 and dmem_error=1 in MEMORY -> stat=3, HALT entered, WRITEBACK never asserted, instr_count unchanged.
- rst asserted during the second MEMORY wait cycle -> next cycle: state IDLE, PC=RESET_PC, mem_req=0, stat=1, instr_count=0.

Source files
------------

// File: rtl/seq_stage_sequencer.sv
// seq_stage_sequencer
// Multi-cycle control FSM for the SEQ Y86-64 core. Steps each instruction
// through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD with one enable
// per stage. Owns the architectural PC, the processor status and the
// retired-instruction counter, and runs the data-memory request/ready
// handshake.
module seq_stage_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        Cnd,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic        mem_ready,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [63:0] instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  // Next-PC selection: taken jump and call go to valC, ret to valM
  function automatic logic [63:0] sel_next_pc(input logic [3:0]  ic,
                                              input logic        cnd,
                                              input logic [63:0] p,
                                              input logic [63:0] c,
                                              input logic [63:0] m);
    if ((ic == IC_JXX) && cnd) return c;
    if (ic == IC_CALL)         return c;
    if (ic == IC_RET)          return m;
    return p;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  r_stat;
  logic [3:0]  r_icode;
  logic [63:0] r_pc;
  logic [63:0] r_count;
  logic        r_fetch_en;
  logic        r_decode_en;
  logic        r_execute_en;
  logic        r_memory_en;
  logic        r_writeback_en;
  logic        r_pc_en;
  logic        r_mem_req;
  logic        r_halted;

  logic [2:0]  w_state_nxt;
  logic [2:0]  w_stat_nxt;
  logic        w_mem_instr;

  // icode is captured at the end of FETCH so later stages see a stable copy
  assign w_mem_instr = is_mem_icode(r_icode);

  // Next-state and status decision for the current stage
  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = S_HALT;
        end else if (!instr_valid) begin
          w_stat_nxt  = STAT_INS;
          w_state_nxt = S_HALT;
        end else if (icode == IC_HALT) begin
          w_stat_nxt  = STAT_HLT;
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!w_mem_instr) begin
          w_state_nxt = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            w_stat_nxt  = STAT_ADR;
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: w_state_nxt = S_PCUPD;
      S_PCUPD:     w_state_nxt = S_FETCH;
      S_HALT:      w_state_nxt = S_HALT;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // State, registered enables/request/status, PC and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_stat         <= STAT_AOK;
      r_pc           <= RESET_PC;
      r_count        <= 64'd0;
      r_fetch_en     <= 1'b0;
      r_decode_en    <= 1'b0;
      r_execute_en   <= 1'b0;
      r_memory_en    <= 1'b0;
      r_writeback_en <= 1'b0;
      r_pc_en        <= 1'b0;
      r_mem_req      <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_stat         <= w_stat_nxt;
      r_fetch_en     <= (w_state_nxt == S_FETCH);
      r_decode_en    <= (w_state_nxt == S_DECODE);
      r_execute_en   <= (w_state_nxt == S_EXECUTE);
      r_memory_en    <= (w_state_nxt == S_MEMORY);
      r_writeback_en <= (w_state_nxt == S_WRITEBACK);
      r_pc_en        <= (w_state_nxt == S_PCUPD);
      r_mem_req      <= (w_state_nxt == S_MEMORY) && w_mem_instr;
      r_halted       <= (w_state_nxt == S_HALT);
      if (r_state == S_PCUPD) begin
        r_pc    <= sel_next_pc(r_icode, Cnd, valP, valC, valM);
        r_count <= r_count + 64'd1;
      end
    end
  end

  // Captured instruction code; pure data, so it carries no reset
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH) r_icode <= icode;
  end

  assign PC           = r_pc;
  assign instr_count  = r_count;
  assign stat         = r_stat;
  assign halted       = r_halted;
  assign mem_req      = r_mem_req;
  assign fetch_en     = r_fetch_en;
  assign decode_en    = r_decode_en;
  assign execute_en   = r_execute_en;
  assign memory_en    = r_memory_en;
  assign writeback_en = r_writeback_en;
  assign pc_en        = r_pc_en;

endmodule
